led_pwm_blinker: RTL

//  Downstream stage of the LED register: takes the 24-bit architectural light state and drives
//  the physical LED pins with global PWM dimming and per-LED blinking.

---
 rtl/led_pwm_blinker_pkg.sv | 14 +
 rtl/led_pwm_blinker_if.sv | 9 +
 rtl/led_pwm_blinker_tick_divider.sv | 25 ++
 rtl/led_pwm_blinker.sv | 103 ++++++++++
 4 files changed

// File: rtl/led_pwm_blinker_pkg.sv
// Shared config-bus types, register addresses and reset values for the LED PWM/blink stage.
package led_cfg_pkg;
  typedef logic [1:0]  cfg_addr_t;
  typedef logic [15:0] cfg_data_t;

  localparam cfg_addr_t LED_CFG_DUTY    = 2'b00;
  localparam cfg_addr_t LED_CFG_MASK_LO = 2'b01;
  localparam cfg_addr_t LED_CFG_MASK_HI = 2'b10;
  localparam cfg_addr_t LED_CFG_CTRL    = 2'b11;

  // Duty resets to full brightness; the top slices off its PWM_BITS.
  localparam cfg_data_t LED_DUTY_RST   = 16'hFFFF;
  localparam logic      LED_ENABLE_RST = 1'b1;
endpackage

// File: rtl/led_pwm_blinker_if.sv
// Write-only MMIO config port: one-cycle write strobe with 2-bit address and 16-bit data.
interface led_pwm_blinker_if;
  logic                  do_cfg_write;
  led_cfg_pkg::cfg_addr_t cfg_address;
  led_cfg_pkg::cfg_data_t cfg_data;

  modport master (output do_cfg_write, cfg_address, cfg_data);
  modport slave  (input  do_cfg_write, cfg_address, cfg_data);
endinterface

// File: rtl/led_pwm_blinker_tick_divider.sv
// Free-running prescaler: counts 0..TICK_CYCLES-1 and pulses tick for one cycle at terminal count.
module tick_divider #(
  parameter int TICK_CYCLES = 23_000
) (
  input  logic iCpuClock,
  input  logic iCpuReset,
  output logic tick
);
  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge iCpuClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/led_pwm_blinker.sv
// Drives LED pins from the light state with global PWM dimming and per-LED blinking.
// One register stage from iLightState/pwm_cnt to oLedPins; config writes land the next cycle.
module led_pwm_blinker
  import led_cfg_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int TICK_CYCLES = 23_000,
  parameter int BLINK_BITS  = 12
) (
  input  logic                iCpuClock,
  input  logic                iCpuReset,
  input  logic [23:0]         iLightState,
  led_pwm_blinker_if.slave    cfg,
  output logic [23:0]         oLedPins,
  output logic                oPwmWrap
);
  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

  logic [PWM_BITS-1:0]   duty_req;
  logic [PWM_BITS-1:0]   duty_act;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic [23:0]           blink_mask;
  logic [3:0]            rate;
  logic                  enable;
  logic                  invert;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic                  tick;
  logic                  phase;
  logic                  pwm_on;
  logic                  pwm_at_max;
  logic [23:0]           raw;

  always_ff @(posedge iCpuClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      duty_req   <= LED_DUTY_RST[PWM_BITS-1:0];
      blink_mask <= '0;
      rate       <= '0;
      enable     <= LED_ENABLE_RST;
      invert     <= 1'b0;
    end else if (cfg.do_cfg_write) begin
      case (cfg.cfg_address)
        LED_CFG_DUTY:    duty_req <= cfg.cfg_data[PWM_BITS-1:0];
        LED_CFG_MASK_LO: blink_mask[15:0] <= cfg.cfg_data;
        LED_CFG_MASK_HI: begin
          blink_mask[23:16] <= cfg.cfg_data[7:0];
          rate              <= cfg.cfg_data[11:8];
        end
        LED_CFG_CTRL: begin
          enable <= cfg.cfg_data[0];
          invert <= cfg.cfg_data[1];
        end
      endcase
    end
  end

  assign pwm_at_max = (pwm_cnt == PWM_MAX);
  assign oPwmWrap   = pwm_at_max;

  // duty_act only moves at the period boundary so brightness never changes mid-period.
  always_ff @(posedge iCpuClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      pwm_cnt  <= '0;
      duty_act <= '1;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_at_max) duty_act <= duty_req;
    end
  end

  assign pwm_on = (duty_act == PWM_MAX) ? 1'b1 : (pwm_cnt < duty_act);

  tick_divider #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .iCpuClock (iCpuClock),
    .iCpuReset (iCpuReset),
    .tick      (tick)
  );

  always_ff @(posedge iCpuClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      blink_cnt <= '0;
    end else if (tick) begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Rates at or beyond the counter width clamp to its MSB.
  always_comb begin
    phase = blink_cnt[BLINK_BITS-1];
    for (int i = 0; i < BLINK_BITS - 1; i++) begin
      if (int'(rate) == i) phase = blink_cnt[i];
    end
  end

  assign raw = {24{enable & pwm_on}} & iLightState & (~blink_mask | {24{phase}});

  always_ff @(posedge iCpuClock or posedge iCpuReset) begin
    if (iCpuReset) begin
      oLedPins <= '0;
    end else begin
      oLedPins <= raw ^ {24{invert}};
    end
  end
endmodule
